// File: rtl/bcd_display_decoder_if.sv
// Keypad-side entry signals and display-side drive signals of the BCD display decoder.
interface bcd_display_decoder_if;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       clear;
    logic [6:0] seg;
    logic [3:0] an;
    logic       full;
    logic       err;

    modport master (
        output digit_in, digit_valid, clear,
        input  seg, an, full, err
    );

    modport slave (
        input  digit_in, digit_valid, clear,
        output seg, an, full, err
    );
endinterface

// File: rtl/bcd_display_decoder.sv
// Four-digit BCD entry register driving a multiplexed seven-segment display,
// with optional blanking of positions that have not been entered yet.
module bcd_display_decoder #(
    parameter int unsigned SCAN_DIV = 32'd4,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_display_decoder_if.slave bus
);
    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 32'd1);

    logic [15:0] digits_r;
    logic [15:0] digits_next_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_next_s;
    logic        reject_s;
    logic [7:0]  div_r;
    logic [1:0]  idx_r;
    logic [3:0]  cur_digit_s;
    logic [6:0]  seg_next_s;
    logic [3:0]  an_next_s;
    logic [6:0]  seg_r;
    logic [3:0]  an_r;
    logic        full_r;
    logic        err_r;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] pos);
        logic [3:0] onehot;
        case (pos)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0001;
        endcase
        return onehot;
    endfunction

    // Entry next-state: clear wins, then accept or reject of a strobed digit.
    always_comb begin
        digits_next_s = digits_r;
        cnt_next_s    = cnt_r;
        reject_s      = 1'b0;
        if (bus.clear) begin
            digits_next_s = 16'h0000;
            cnt_next_s    = 3'd0;
        end else if (bus.digit_valid) begin
            if ((bus.digit_in > 4'd9) || (cnt_r == 3'd4)) begin
                reject_s = 1'b1;
            end else begin
                digits_next_s = {digits_r[11:0], bus.digit_in};
                cnt_next_s    = cnt_r + 3'd1;
            end
        end else begin
            reject_s = 1'b0;
        end
    end

    // Display next-state for the position currently selected by the scan index.
    always_comb begin
        case (idx_r)
            2'd0:    cur_digit_s = digits_r[3:0];
            2'd1:    cur_digit_s = digits_r[7:4];
            2'd2:    cur_digit_s = digits_r[11:8];
            2'd3:    cur_digit_s = digits_r[15:12];
            default: cur_digit_s = 4'd0;
        endcase
        an_next_s = one_hot(idx_r);
        // Position 0 is never blanked so an empty entry still reads as "0".
        if (BLANK_LZ && (idx_r != 2'd0) && ({1'b0, idx_r} >= cnt_r)) begin
            seg_next_s = 7'h00;
        end else begin
            seg_next_s = bcd_to_seg(cur_digit_s);
        end
    end

    // Entry registers: held digits, count, full flag and reject pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_r <= 16'h0000;
            cnt_r    <= 3'd0;
            full_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            digits_r <= digits_next_s;
            cnt_r    <= cnt_next_s;
            full_r   <= (cnt_next_s == 3'd4);
            err_r    <= reject_s;
        end
    end

    // Scan divider, scan index and registered segment/anode drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= 8'd0;
            idx_r <= 2'd0;
            seg_r <= 7'h3F;
            an_r  <= 4'b0001;
        end else begin
            seg_r <= seg_next_s;
            an_r  <= an_next_s;
            if (div_r == DIV_LAST) begin
                div_r <= 8'd0;
                idx_r <= idx_r + 2'd1;
            end else begin
                div_r <= div_r + 8'd1;
            end
        end
    end

    assign bus.seg  = seg_r;
    assign bus.an   = an_r;
    assign bus.full = full_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_bcd_display_decoder.sv
// Directed bench for bcd_display_decoder: expected outputs are queued as each
// cycle's stimulus is applied and compared once the DUT has clocked it.
module tb_bcd_display_decoder;
    localparam int SCAN = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_display_decoder_if bus ();

    bcd_display_decoder #(
        .SCAN_DIV (SCAN),
        .BLANK_LZ (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       full;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model state: digits d[3..0], count, and edges since reset release.
    int m_d[4];
    int m_cnt;
    int m_cyc;

    function automatic logic [6:0] ref_seg(input int v);
        logic [6:0] tab [10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tab[v];
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_cnt = 0;
        m_cyc = 0;
    endtask

    // One clock: drive inputs, queue the expectation, clock, pop and compare.
    task automatic cycle(input string tag, input logic v, input logic [3:0] d, input logic c);
        exp_t e;
        exp_t got;
        int   pos;
        bus.digit_valid = v;
        bus.digit_in    = d;
        bus.clear       = c;
        pos   = (m_cyc / SCAN) % 4;
        e.an  = 4'b0001 << pos;
        e.seg = (pos != 0 && pos >= m_cnt) ? 7'h00 : ref_seg(m_d[pos]);
        e.err = (v && !c && (d > 4'd9 || m_cnt == 4)) ? 1'b1 : 1'b0;
        if (c) begin
            for (int i = 0; i < 4; i++) m_d[i] = 0;
            m_cnt = 0;
        end else if (v && d <= 4'd9 && m_cnt < 4) begin
            m_d[3] = m_d[2];
            m_d[2] = m_d[1];
            m_d[1] = m_d[0];
            m_d[0] = int'(d);
            m_cnt++;
        end
        e.full = (m_cnt == 4) ? 1'b1 : 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        m_cyc++;
        got = sb.pop_front();
        check({tag, ".seg"},  bus.seg,               got.seg);
        check({tag, ".an"},   {3'b000, bus.an},      {3'b000, got.an});
        check({tag, ".full"}, {6'b000000, bus.full}, {6'b000000, got.full});
        check({tag, ".err"},  {6'b000000, bus.err},  {6'b000000, got.err});
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        bus.digit_in    = 4'd0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".seg"},  bus.seg,               7'h3F);
        check({tag, ".an"},   {3'b000, bus.an},      7'h01);
        check({tag, ".full"}, {6'b000000, bus.full}, 7'h00);
        check({tag, ".err"},  {6'b000000, bus.err},  7'h00);
    endtask

    initial begin
        rst             = 1'b1;
        bus.digit_in    = 4'd0;
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        model_reset();
        #3;
        check_reset_values("reset_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Empty display: only position 0 lit with "0".
        idle("idle_scan", 16);

        // Enter 1,2,3,0 and watch every position.
        cycle("enter1", 1'b1, 4'd1, 1'b0);
        cycle("enter2", 1'b1, 4'd2, 1'b0);
        cycle("enter3", 1'b1, 4'd3, 1'b0);
        cycle("enter0", 1'b1, 4'd0, 1'b0);
        idle("show1230", 16);

        // Fifth digit while full is rejected.
        cycle("fifth7", 1'b1, 4'd7, 1'b0);
        idle("after_fifth", 16);

        // Clear, then a non-BCD code followed by a legal digit.
        cycle("clear_a", 1'b0, 4'd0, 1'b1);
        cycle("enter4", 1'b1, 4'd4, 1'b0);
        cycle("digitA", 1'b1, 4'hA, 1'b0);
        cycle("enter5", 1'b1, 4'd5, 1'b0);
        idle("show45", 16);

        // Clear and digit 9 together: clear wins, no error.
        cycle("clear_and_9", 1'b1, 4'd9, 1'b1);
        idle("after_clear", 16);

        // Asynchronous reset between edges with two digits held.
        cycle("enter8", 1'b1, 4'd8, 1'b0);
        cycle("enter6", 1'b1, 4'd6, 1'b0);
        idle("show86", 5);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        check_reset_values("rst_held");
        rst = 1'b0;
        model_reset();
        idle("post_rst_scan", 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
